// File: rtl/alu32_if.sv
// Operand/opcode and registered result/flag bundle for the alu32 execute-stage ALU.
interface alu32_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opcode;
  logic [31:0] result;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic        overflow_flag;

  modport master (
    output a, b, opcode,
    input  result, zero_flag, sign_flag, carry_flag, overflow_flag
  );

  modport slave (
    input  a, b, opcode,
    output result, zero_flag, sign_flag, carry_flag, overflow_flag
  );
endinterface

// File: rtl/alu32.sv
// 32-bit execute-stage ALU: add/sub/logic/slt/shifts with zero/sign/carry/overflow flags.
// Operands are sampled every clock; result and flags are registered (1-cycle latency).
module alu32 (
  input  logic   clk,
  input  logic   rst,
  alu32_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] r);
    return (x[31] == y[31]) && (r[31] != x[31]);
  endfunction

  // Signed overflow for x - y: operands differ in sign and result sign flips from x.
  function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] r);
    return (x[31] != y[31]) && (r[31] != x[31]);
  endfunction

  logic [32:0]        sum_s;
  logic [32:0]        diff_s;
  logic [4:0]         shamt_s;
  logic signed [31:0] a_signed_s;
  logic [31:0]        next_result_s;
  logic               next_carry_s;
  logic               next_ovf_s;

  logic [31:0] result_r;
  logic        zero_r;
  logic        sign_r;
  logic        carry_r;
  logic        ovf_r;

  assign sum_s      = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_s     = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt_s    = bus.b[4:0];
  assign a_signed_s = bus.a;

  // Next result and arithmetic flags; diff_s[32] is the unsigned borrow.
  always_comb begin
    next_result_s = 32'd0;
    next_carry_s  = 1'b0;
    next_ovf_s    = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        next_result_s = sum_s[31:0];
        next_carry_s  = sum_s[32];
        next_ovf_s    = add_ovf(bus.a, bus.b, sum_s[31:0]);
      end
      OP_SUB: begin
        next_result_s = diff_s[31:0];
        next_carry_s  = diff_s[32];
        next_ovf_s    = sub_ovf(bus.a, bus.b, diff_s[31:0]);
      end
      OP_AND: next_result_s = bus.a & bus.b;
      OP_OR:  next_result_s = bus.a | bus.b;
      OP_XOR: next_result_s = bus.a ^ bus.b;
      OP_SLT: begin
        if ($signed(bus.a) < $signed(bus.b)) begin
          next_result_s = 32'd1;
        end else begin
          next_result_s = 32'd0;
        end
      end
      OP_SLL: next_result_s = bus.a << shamt_s;
      OP_SRL: next_result_s = bus.a >> shamt_s;
      OP_SRA: next_result_s = a_signed_s >>> shamt_s;
      default: begin
        next_result_s = 32'd0;
        next_carry_s  = 1'b0;
        next_ovf_s    = 1'b0;
      end
    endcase
  end

  // Output register; zero/sign are derived from the value being registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= 32'd0;
      zero_r   <= 1'b1;
      sign_r   <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      result_r <= next_result_s;
      zero_r   <= (next_result_s == 32'd0);
      sign_r   <= next_result_s[31];
      carry_r  <= next_carry_s;
      ovf_r    <= next_ovf_s;
    end
  end

  assign bus.result        = result_r;
  assign bus.zero_flag     = zero_r;
  assign bus.sign_flag     = sign_r;
  assign bus.carry_flag    = carry_r;
  assign bus.overflow_flag = ovf_r;
endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed corner vectors, randomized ops against an
// arithmetic reference model, back-to-back latency, mid-stream reset and reserved opcodes.
module tb_alu32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu32_if bus ();

  alu32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;  // {Z,S,C,V}
  } vec_t;

  localparam int NVEC = 20;
  localparam vec_t VECS [0:NVEC-1] = '{
    '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010},
    '{4'h0, 32'd10,       32'd20,       32'd30,       4'b0000},
    '{4'h0, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 4'b0101},
    '{4'h1, 32'd10,       32'd20,       32'hFFFFFFF6, 4'b0110},
    '{4'h1, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0001},
    '{4'h2, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b1000},
    '{4'h3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0100},
    '{4'h4, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000},
    '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000},
    '{4'h5, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 4'b0000},
    '{4'h5, 32'd10,       32'd10,       32'h00000000, 4'b1000},
    '{4'h5, 32'd20,       32'd10,       32'h00000000, 4'b1000},
    '{4'h6, 32'h00000001, 32'd31,       32'h80000000, 4'b0100},
    '{4'h6, 32'h80000000, 32'd1,        32'h00000000, 4'b1000},
    '{4'h7, 32'hFFFF0000, 32'd2,        32'h3FFFC000, 4'b0000},
    '{4'h8, 32'hFFFF0000, 32'd2,        32'hFFFFC000, 4'b0100},
    '{4'h8, 32'h80000000, 32'd1,        32'hC0000000, 4'b0100},
    '{4'h6, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 4'b0000},
    '{4'h7, 32'h87654321, 32'h00000000, 32'h87654321, 4'b0100},
    '{4'hF, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'b1000}
  };

  // Reference model: result and flags from plain integer arithmetic, {r,Z,S,C,V}.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint ua, ub, sa, sb, p, t;
    logic [31:0] r;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 1;
    for (int i = 0; i < int'(b[4:0]); i++) p = p * 2;
    c = 1'b0;
    v = 1'b0;
    r = 32'd0;
    case (op)
      4'd0: begin
        t = ua + ub;
        r = 32'(t % 64'sd4294967296);
        c = (t >= 64'sd4294967296);
        v = ((sa + sb) > 64'sd2147483647) || ((sa + sb) < -64'sd2147483648);
      end
      4'd1: begin
        t = ua - ub;
        if (t < 0) t = t + 64'sd4294967296;
        r = 32'(t);
        c = (ua < ub);
        v = ((sa - sb) > 64'sd2147483647) || ((sa - sb) < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = 32'((ua * p) % 64'sd4294967296);
      4'd7: r = 32'(ua / p);
      4'd8: begin
        if (sa >= 0) t = sa / p;
        else t = -(((-sa) + p - 1) / p);
        r = 32'(t);
      end
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  // Apply one op and let it be registered; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.opcode = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] observed();
    return {bus.result, bus.zero_flag, bus.sign_flag, bus.carry_flag, bus.overflow_flag};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(4'h0, 32'hFFFFFFFF, 32'd1);
    step(4'h0, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (observed() !== {32'd0, 4'b1000}) begin
      errors++;
      $display("FAIL reset: got %h expected %h", observed(), {32'd0, 4'b1000});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < NVEC; i++) begin
      step(VECS[i].op, VECS[i].a, VECS[i].b);
      checks++;
      if (observed() !== {VECS[i].r, VECS[i].f}) begin
        errors++;
        $display("FAIL directed[%0d] op=%h a=%h b=%h: got %h expected %h", i, VECS[i].op,
                 VECS[i].a, VECS[i].b, observed(), {VECS[i].r, VECS[i].f});
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [35:0] exp;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'h7FFFFFFF;
      if ($urandom_range(0, 9) == 0) b = a;
      exp = model(op, a, b);
      step(op, a, b);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL random op=%h a=%h b=%h: got %h expected %h", op, a, b, observed(), exp);
      end
    end
  endtask

  // Outputs must still hold the previous op just before the edge, then show the new one.
  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [35:0] prev, exp;
    prev = observed();
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 8));
      a = $urandom();
      b = $urandom();
      exp = model(op, a, b);
      bus.opcode = op;
      bus.a = a;
      bus.b = b;
      #2;
      checks++;
      if (observed() !== prev) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: got %h expected %h", i, observed(), prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL b2b_next[%0d]: got %h expected %h", i, observed(), exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_reset_midstream();
    logic [35:0] exp;
    step(4'h0, 32'd100, 32'd23);
    checks++;
    if (observed() !== {32'd123, 4'b0000}) begin
      errors++;
      $display("FAIL mid_before: got %h expected %h", observed(), {32'd123, 4'b0000});
    end
    rst = 1'b1;
    step(4'h3, 32'hFFFFFFFF, 32'h1);
    rst = 1'b0;
    checks++;
    if (observed() !== {32'd0, 4'b1000}) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", observed(), {32'd0, 4'b1000});
    end
    exp = model(4'h1, 32'd5, 32'd7);
    step(4'h1, 32'd5, 32'd7);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL mid_resume: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_reserved();
    for (int op = 9; op < 16; op++) begin
      step(4'(op), $urandom(), $urandom());
      checks++;
      if (observed() !== {32'd0, 4'b1000}) begin
        errors++;
        $display("FAIL reserved op=%0d: got %h expected %h", op, observed(), {32'd0, 4'b1000});
      end
    end
  endtask

  initial begin
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.opcode = 4'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    test_reserved();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
